dsp_div: RTL and testbench

Iterative signed divider that undoes the team's add-multiply DSP stage: given a 2·DW-bit signed product and a DW-bit signed divisor, it recovers the quotient and remainder. It sits on the consumer side of the DSP product stream, behind an AXI-Stream-style valid/ready handshake on both the input and output sides. It uses a restoring shift-subtract algorithm, producing one quotient bit per clock, with fixed latency and one operation in flight at a time.

---
 rtl/dsp_pkg.sv | 29 ++
 rtl/dsp_div_step.sv | 40 ++++
 rtl/dsp_div.sv | 202 ++++++++++++++++++++
 tb/tb_dsp_div.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_pkg.sv
// Shared types and constants for the dsp_div iterative divider.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package dsp_pkg;

   // Default operand width of the DSP product stream.
   localparam int DSP_DW = 8;

   // One quotient bit is produced per iteration, so a 2*DW-bit dividend
   // needs 2*DW iterations.
   localparam int DIV_ITERS = 2 * DSP_DW;

   // Bit positions inside m_tstatus.
   localparam int DBZ_BIT = 0;
   localparam int OVF_BIT = 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } dsp_div_state_t;

   // Iteration count for an arbitrary operand width.
   function automatic int div_iters(input int dw);
      return 2 * dw;
   endfunction

endpackage

// File: rtl/dsp_div_step.sv
// One restoring shift-subtract iteration of the dsp_div divider.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, consumed only while dividing.
//
// Ports:
//   rem_in  [DW:0]  partial remainder (magnitude)
//   bit_in          next dividend bit shifted into the remainder
//   dvs     [DW:0]  divisor magnitude
//   rem_out [DW:0]  next partial remainder
//   q_bit           quotient bit produced by this iteration
module dsp_div_step
   import dsp_pkg::*;
#(
   parameter int DW = DSP_DW
) (
   input  logic [DW:0] rem_in,
   input  logic        bit_in,
   input  logic [DW:0] dvs,
   output logic [DW:0] rem_out,
   output logic        q_bit
);

   logic [DW+1:0] shifted;
   logic [DW+2:0] diff;
   logic [1:0]    unused_bits;

   assign shifted = {rem_in, bit_in};

   // One extra bit on top so the borrow of the trial subtraction is explicit.
   assign diff = {1'b0, shifted} - {2'b00, dvs};

   assign q_bit   = ~diff[DW+2];
   assign rem_out = q_bit ? diff[DW:0] : shifted[DW:0];

   // With a non-zero divisor the kept remainder is below 2^(DW-1), so these
   // top bits never carry information; with a zero divisor the result is
   // discarded anyway.
   assign unused_bits = {diff[DW+1], shifted[DW+1]};

endmodule

// File: rtl/dsp_div.sv
// Iterative signed divider (restoring, one quotient bit per clock) that
// recovers quotient/remainder from a 2*DW-bit product and a DW-bit divisor.
// Latency: m_tvalid rises 2*DW+1 clocks after the input handshake edge.
// Backpressure: one op in flight; s_tready only in IDLE; result held until m_tready.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   s_tvalid/s_tready        input handshake
//   s_tdividend [2*DW-1:0]   signed dividend
//   s_tdivisor  [DW-1:0]     signed divisor
//   m_tvalid/m_tready        output handshake
//   m_tquot     [2*DW-1:0]   signed quotient, truncated toward zero
//   m_trem      [DW-1:0]     signed remainder, sign of the dividend
//   m_tstatus   [1:0]        {ovf, dbz}; only when DSP_DIV_STATUS_EN is defined
module dsp_div
   import dsp_pkg::*;
#(
   parameter int DW = DSP_DW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            s_tvalid,
   output logic            s_tready,
   input  logic [2*DW-1:0] s_tdividend,
   input  logic [DW-1:0]   s_tdivisor,
   output logic            m_tvalid,
   input  logic            m_tready,
   output logic [2*DW-1:0] m_tquot,
   output logic [DW-1:0]   m_trem
`ifdef DSP_DIV_STATUS_EN
   ,
   output logic [1:0]      m_tstatus
`endif
);

   localparam int ITERS = div_iters(DW);
   localparam int CW    = $clog2(ITERS);
   localparam logic [CW-1:0] LAST_ITER = CW'(ITERS - 1);

   dsp_div_state_t state, state_nxt;

   // Working registers. The dividend register shifts left each iteration and
   // collects quotient bits at its LSB, so it ends up holding |quotient|.
   logic [2*DW-1:0] dvd_q;
   logic [DW:0]     dvs_q;
   logic [DW:0]     prem_q;
   logic [CW-1:0]   cnt_q;
   logic            sgn_dvd_q;
   logic            sgn_dvs_q;
   logic            dbz_q;
`ifdef DSP_DIV_STATUS_EN
   logic            ovf_q;
   logic            in_ovf;
`endif

   logic            accept;
   logic            last_iter;
   logic            s_tready_nxt;
   logic            m_tvalid_nxt;

   logic [2*DW-1:0] dvd_abs;
   logic [DW:0]     dvs_ext;
   logic [DW:0]     dvs_abs;
   logic            in_dbz;

   logic [DW:0]     step_rem;
   logic            step_q;

   logic [2*DW-1:0] quot_res;
   logic [DW-1:0]   rem_mag;
   logic [DW-1:0]   rem_res;

   assign accept    = (state == IDLE) && s_tvalid && s_tready;
   assign last_iter = (cnt_q == LAST_ITER);

   // ---------------- operand conditioning ----------------
   // The divisor is sign-extended by one bit first so that -2^(DW-1) has an
   // exact magnitude.
   always_comb begin
      dvd_abs = s_tdividend[2*DW-1] ? (~s_tdividend + 1'b1) : s_tdividend;
      dvs_ext = {s_tdivisor[DW-1], s_tdivisor};
      dvs_abs = dvs_ext[DW] ? (~dvs_ext + 1'b1) : dvs_ext;
      in_dbz  = (s_tdivisor == '0);
   end

`ifdef DSP_DIV_STATUS_EN
   assign in_ovf = (s_tdividend == {1'b1, {(2*DW-1){1'b0}}}) &&
                   (s_tdivisor == {DW{1'b1}});
`endif

   // ---------------- single shared iteration stage ----------------
   dsp_div_step #(.DW(DW)) u_step (
      .rem_in  (prem_q),
      .bit_in  (dvd_q[2*DW-1]),
      .dvs     (dvs_q),
      .rem_out (step_rem),
      .q_bit   (step_q)
   );

   // ---------------- sign fix-up ----------------
   // The overflow case needs no special path: |-2^(2DW-1)| / 1 leaves
   // 0x80..0 in the quotient register, which already is the wrapped result.
   always_comb begin
      quot_res = (sgn_dvd_q ^ sgn_dvs_q) ? (~dvd_q + 1'b1) : dvd_q;
      rem_mag  = prem_q[DW-1:0];
      rem_res  = sgn_dvd_q ? (~rem_mag + 1'b1) : rem_mag;
      if (dbz_q) begin
         quot_res = '0;
         rem_res  = '0;
      end
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (accept) state_nxt = DIV;
         DIV:  if (last_iter) state_nxt = FIX;
         FIX:  state_nxt = DONE;
         DONE: if (m_tvalid && m_tready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   // Handshake outputs are decoded from the next state and registered, so
   // they change on the same edge as the state they describe.
   always_comb begin
      s_tready_nxt = (state_nxt == IDLE);
      m_tvalid_nxt = (state_nxt == DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s_tready <= 1'b0;
         m_tvalid <= 1'b0;
      end else begin
         s_tready <= s_tready_nxt;
         m_tvalid <= m_tvalid_nxt;
      end
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         dvd_q     <= '0;
         dvs_q     <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         sgn_dvd_q <= 1'b0;
         sgn_dvs_q <= 1'b0;
         dbz_q     <= 1'b0;
         m_tquot   <= '0;
         m_trem    <= '0;
`ifdef DSP_DIV_STATUS_EN
         ovf_q     <= 1'b0;
         m_tstatus <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  dvd_q     <= dvd_abs;
                  dvs_q     <= dvs_abs;
                  prem_q    <= '0;
                  cnt_q     <= '0;
                  sgn_dvd_q <= s_tdividend[2*DW-1];
                  sgn_dvs_q <= s_tdivisor[DW-1];
                  dbz_q     <= in_dbz;
`ifdef DSP_DIV_STATUS_EN
                  ovf_q     <= in_ovf;
`endif
               end
            end
            DIV: begin
               dvd_q  <= {dvd_q[2*DW-2:0], step_q};
               prem_q <= step_rem;
               cnt_q  <= cnt_q + 1'b1;
            end
            FIX: begin
               m_tquot <= quot_res;
               m_trem  <= rem_res;
`ifdef DSP_DIV_STATUS_EN
               m_tstatus[DBZ_BIT] <= dbz_q;
               m_tstatus[OVF_BIT] <= ovf_q;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_div.sv
// Self-checking bench for dsp_div (DW = 8): directed vectors, scoreboard
// queue filled by the driver, monitor pops on every output handshake.
module tb_dsp_div;

   localparam int DW = 8;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            s_tvalid = 1'b0;
   logic            s_tready;
   logic [2*DW-1:0] s_tdividend = '0;
   logic [DW-1:0]   s_tdivisor = '0;
   logic            m_tvalid;
   logic            m_tready = 1'b0;
   logic [2*DW-1:0] m_tquot;
   logic [DW-1:0]   m_trem;
`ifdef DSP_DIV_STATUS_EN
   logic [1:0]      m_tstatus;
`endif

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct {
      logic [15:0] q;
      logic [7:0]  r;
      logic [1:0]  st;
   } exp_t;

   typedef struct {
      logic [15:0] a;
      logic [7:0]  b;
      logic [15:0] q;
      logic [7:0]  r;
      logic [1:0]  st;
   } vec_t;

   exp_t sbq[$];

   dsp_div #(.DW(DW)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_tvalid    (s_tvalid),
      .s_tready    (s_tready),
      .s_tdividend (s_tdividend),
      .s_tdivisor  (s_tdivisor),
      .m_tvalid    (m_tvalid),
      .m_tready    (m_tready),
      .m_tquot     (m_tquot),
      .m_trem      (m_trem)
`ifdef DSP_DIV_STATUS_EN
      ,
      .m_tstatus   (m_tstatus)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_tot++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, want %0h", name, got, want);
   endtask

   // Drive one operation; waits (bounded) for s_tready, accepts on the next edge.
   task automatic issue(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] q, input logic [7:0] r,
                        input logic [1:0] st, input bit expect_out);
      int t = 0;
      exp_t e;
      s_tdividend = a;
      s_tdivisor  = b;
      s_tvalid    = 1'b1;
      while (!s_tready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("accept_in_time", 32'(t < 100), 32'd1);
      if (expect_out) begin
         e.q = q; e.r = r; e.st = st;
         sbq.push_back(e);
      end
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   // Counts clock edges from the accept edge until m_tvalid is first seen.
   task automatic wait_valid(output int lat);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!m_tvalid && n < 60);
      lat = n - 1;
   endtask

   // Monitor: compares every result that leaves the DUT.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (m_tvalid && m_tready) begin
            chk("result_was_expected", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) begin
               e = sbq.pop_front();
               chk("quot", 32'(m_tquot), 32'(e.q));
               chk("rem", 32'(m_trem), 32'(e.r));
`ifdef DSP_DIV_STATUS_EN
               chk("status", 32'(m_tstatus), 32'(e.st));
`endif
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [0:10];
      int lat;
      int seen;
      int t;

      vecs = '{
         '{16'd300,  8'd10,  16'd30,   8'd0,   2'b00},  // nominal
         '{16'hFFF9, 8'd2,   16'hFFFD, 8'hFF,  2'b00},  // -7 / 2
         '{16'd7,    8'hFE,  16'hFFFD, 8'h01,  2'b00},  // 7 / -2
         '{16'hFFF9, 8'hFE,  16'd3,    8'hFF,  2'b00},  // -7 / -2
         '{16'h8000, 8'h80,  16'd256,  8'd0,   2'b00},  // -32768 / -128
         '{16'd1234, 8'd0,   16'd0,    8'd0,   2'b01},  // divide by zero
         '{16'h8000, 8'hFF,  16'h8000, 8'd0,   2'b10},  // overflow
         '{16'hFC18, 8'd7,   16'hFF72, 8'hFA,  2'b00},  // -1000 / 7
         '{16'h7FFF, 8'h7F,  16'h0102, 8'h01,  2'b00},  // 32767 / 127
         '{16'hFFF9, 8'd0,   16'd0,    8'd0,   2'b01},  // -7 / 0
         '{16'h8000, 8'd1,   16'h8000, 8'd0,   2'b00}   // -32768 / 1, no ovf
      };

      // ---- reset state ----
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_s_tready", 32'(s_tready), 32'd0);
      chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("rst_m_tquot", 32'(m_tquot), 32'd0);
      chk("rst_m_trem", 32'(m_trem), 32'd0);
`ifdef DSP_DIV_STATUS_EN
      chk("rst_m_tstatus", 32'(m_tstatus), 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("s_tready_before_first_edge", 32'(s_tready), 32'd0);
      @(negedge clk);
      chk("s_tready_after_release", 32'(s_tready), 32'd1);

      // ---- directed vectors, no output stall ----
      m_tready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].st, 1'b1);
         wait_valid(lat);
         chk($sformatf("latency_vec%0d", i), 32'(lat), 32'd17);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b0;

      // ---- backpressure: hold result for 5 cycles ----
      issue(16'd100, 8'd7, 16'd14, 8'd2, 2'b00, 1'b1);
      wait_valid(lat);
      chk("bp_latency", 32'(lat), 32'd17);
      for (int i = 0; i < 5; i++) begin
         chk("bp_m_tvalid_held", 32'(m_tvalid), 32'd1);
         chk("bp_s_tready_low", 32'(s_tready), 32'd0);
         chk("bp_quot_stable", 32'(m_tquot), 32'd14);
         chk("bp_rem_stable", 32'(m_trem), 32'd2);
         @(negedge clk);
      end

      // Release the stall with the next operation already waiting.
      @(posedge clk);
      #1;
      m_tready    = 1'b1;
      s_tdividend = 16'hFC18;
      s_tdivisor  = 8'd7;
      s_tvalid    = 1'b1;
      begin
         exp_t e2;
         e2.q = 16'hFF72; e2.r = 8'hFA; e2.st = 2'b00;
         sbq.push_back(e2);
      end
      @(negedge clk);
      chk("s_tready_during_out_hs", 32'(s_tready), 32'd0);
      @(negedge clk);
      chk("m_tvalid_dropped", 32'(m_tvalid), 32'd0);
      chk("s_tready_after_out_hs", 32'(s_tready), 32'd1);
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
      wait_valid(lat);
      chk("b2b_latency", 32'(lat), 32'd17);

      // ---- reset in the 5th DIV cycle ----
      @(posedge clk);
      #1;
      issue(16'd50, 8'd3, 16'd0, 8'd0, 2'b00, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      chk("abort_m_tvalid", 32'(m_tvalid), 32'd0);
      chk("abort_m_tquot", 32'(m_tquot), 32'd0);
      chk("abort_m_trem", 32'(m_trem), 32'd0);
      chk("abort_s_tready_in_reset", 32'(s_tready), 32'd0);
      @(negedge clk);
      chk("abort_s_tready_after", 32'(s_tready), 32'd1);
      seen = 0;
      repeat (25) begin
         @(negedge clk);
         if (m_tvalid) seen++;
      end
      chk("abort_no_result", 32'(seen), 32'd0);

      issue(16'd50, 8'd3, 16'd16, 8'd2, 2'b00, 1'b1);
      wait_valid(lat);
      chk("post_abort_latency", 32'(lat), 32'd17);

      // ---- drain scoreboard ----
      t = 0;
      while (sbq.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_drained", 32'(sbq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
